// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants for BCD digit capture and 7-segment display
//
// Purpose: segment patterns, BCD limits and filter counter sizing shared by
// bcd_digit_display and bcd_to_seg (and any other display block).
// Ports: none (package).

package bcd_pkg;

  // Largest legal BCD digit; the carry fires on the wrap from this value to 0.
  localparam int BCD_MAX = 9;

  // Match counter width, large enough for STABLE_CYCLES up to 15.
  localparam int CNT_W = 4;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, active-high.
  localparam logic [6:0] SEG_0    = 7'b0111111;
  localparam logic [6:0] SEG_1    = 7'b0000110;
  localparam logic [6:0] SEG_2    = 7'b1011011;
  localparam logic [6:0] SEG_3    = 7'b1001111;
  localparam logic [6:0] SEG_4    = 7'b1100110;
  localparam logic [6:0] SEG_5    = 7'b1101101;
  localparam logic [6:0] SEG_6    = 7'b1111101;
  localparam logic [6:0] SEG_7    = 7'b0000111;
  localparam logic [6:0] SEG_8    = 7'b1111111;
  localparam logic [6:0] SEG_9    = 7'b1101111;
  localparam logic [6:0] SEG_DASH = 7'b1000000;

  // Active-high pattern for a 4-bit code; non-BCD codes show a dash.
  function automatic logic [6:0] bcd_seg_pattern(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// rtl/bcd_to_seg.sv - combinational BCD to 7-segment decoder
//
// Purpose: maps a 4-bit code to segment drive; codes 10..15 show a dash and
// raise invalid. ACTIVE_LOW inverts the segment drive only.
// Ports:
//   digit   in  [3:0] code to display
//   seg     out [6:0] segment drive {g,f,e,d,c,b,a}
//   invalid out       1 when digit is outside 0..9

module bcd_to_seg
  import bcd_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic [3:0] digit,
  output logic [6:0] seg,
  output logic       invalid
);

  logic [6:0] pattern;

  always_comb begin
    pattern = bcd_seg_pattern(digit);
    invalid = (digit > 4'(BCD_MAX));
    seg     = ACTIVE_LOW ? ~pattern : pattern;
  end

endmodule

// File: rtl/bcd_digit_display.sv
// rtl/bcd_digit_display.sv - filtered capture of a ripple BCD counter onto a 7-segment display
//
// Purpose: synchronizes the asynchronous {q8,q4,q2,q1} code, accepts it only
// after it has been steady for STABLE_CYCLES, holds it in a display register
// and emits a one-clock carry on each 9->0 wrap of the displayed digit.
// Ports:
//   clock           in        system clock, rising edge
//   reset           in        asynchronous active-low reset
//   q1, q2, q4, q8  in        BCD bits from the ripple counter (async)
//   hold            in        1 freezes the display register (sync)
//   digit           out [3:0] accepted code currently displayed
//   seg             out [6:0] segment drive {g,f,e,d,c,b,a}
//   carry           out       one-clock pulse after digit wraps 9->0
//   invalid         out       1 while digit holds 10..15

module bcd_digit_display
  import bcd_pkg::*;
#(
  parameter int STABLE_CYCLES  = 2,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       q1,
  input  logic       q2,
  input  logic       q4,
  input  logic       q8,
  input  logic       hold,
  output logic [3:0] digit,
  output logic [6:0] seg,
  output logic       carry,
  output logic       invalid
);

  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

  logic [3:0]       s1;
  logic [3:0]       s2;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;
  logic [3:0]       digit_prev;

  // s1 holds the value s2 takes on this edge, so s1 != s2 means s2 is about
  // to differ from its previous-cycle value and the run length restarts.
  // The counter saturates, so a code that stays steady remains accepted and
  // can still be loaded when hold is released.
  always_comb begin
    cnt_next = match_cnt;
    if (s1 != s2) begin
      cnt_next = '0;
    end else if (match_cnt != STABLE) begin
      cnt_next = match_cnt + CNT_W'(1);
    end
    accept = (cnt_next == STABLE);
  end

  // digit_prev lags digit by one clock; seeing 9 there with 0 in digit means
  // the display just wrapped, so carry rises on the following edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1         <= '0;
      s2         <= '0;
      match_cnt  <= '0;
      digit      <= '0;
      digit_prev <= '0;
      carry      <= 1'b0;
    end else begin
      s1         <= {q8, q4, q2, q1};
      s2         <= s1;
      match_cnt  <= cnt_next;
      if (accept && !hold) begin
        digit <= s2;
      end
      digit_prev <= digit;
      carry      <= (digit_prev == 4'(BCD_MAX)) && (digit == 4'd0);
    end
  end

  bcd_to_seg #(
    .ACTIVE_LOW (SEG_ACTIVE_LOW)
  ) u_bcd_to_seg (
    .digit   (digit),
    .seg     (seg),
    .invalid (invalid)
  );

endmodule
